// File: rtl/branch_resolver.sv
// branch_resolver: in-order queue of predicted branches checked against execute outcomes.
// Ports: pred_* (fetch push), res_* (execute resolve), upd_* (predictor training), flush/redirect_pc, count.
module branch_resolver #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        pred_valid,
  input  logic [31:0] pred_pc,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  output logic        pred_ready,
  input  logic        res_valid,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  logic        ext_flush,
  output logic        upd_en,
  output logic        upd_res,
  output logic [31:0] upd_addr,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] C1 = (AW+1)'(1);
  localparam logic [AW-1:0] P1 = AW'(1);

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  ent_t          q [DEPTH];
  ent_t          hd;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  logic do_push;
  logic do_res;
  logic mis;
  logic do_pop;
  logic clr;
  logic wr;

  assign pred_ready = (count != FULL) & ~flush;
  assign hd = q[head];

  assign do_push = rdy & pred_valid & pred_ready & ~ext_flush;
  assign do_res  = rdy & res_valid & (count != '0) & ~ext_flush;
  assign mis     = (hd.taken != res_taken)
                 | (hd.taken & res_taken & (hd.target != res_target));
  assign do_pop  = do_res & ~mis;
  // a mispredict or external flush wipes the queue and drops any push
  assign clr     = rdy & (ext_flush | (do_res & mis));
  assign wr      = do_push & ~clr;

  always_ff @(posedge clk) begin
    if (wr) q[tail] <= {pred_pc, pred_taken, pred_target};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      upd_en      <= 1'b0;
      upd_res     <= 1'b0;
      upd_addr    <= '0;
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else if (rdy) begin
      upd_en <= do_res;
      flush  <= do_res & mis;
      if (do_res) begin
        upd_res  <= res_taken;
        upd_addr <= hd.pc;
      end
      if (do_res & mis)
        redirect_pc <= res_taken ? res_target : hd.pc + 32'd4;
      if (clr) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (wr) tail <= tail + P1;
        if (do_pop) head <= head + P1;
        unique case (1'b1)
          wr & ~do_pop: count <= count + C1;
          do_pop & ~wr: count <= count - C1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed checks of branch_resolver.
// Expected values are hand-computed per step.
module tb_branch_resolver;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_ready;
  logic        res_valid;
  logic        res_taken;
  logic [31:0] res_target;
  logic        ext_flush;
  logic        upd_en;
  logic        upd_res;
  logic [31:0] upd_addr;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  branch_resolver #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken),
    .res_target(res_target), .ext_flush(ext_flush),
    .upd_en(upd_en), .upd_res(upd_res), .upd_addr(upd_addr),
    .flush(flush), .redirect_pc(redirect_pc), .count(count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic [31:0] pc, input logic tk,
                          input logic [31:0] tg);
    pred_valid  = 1;
    pred_pc     = pc;
    pred_taken  = tk;
    pred_target = tg;
  endtask

  task automatic set_res(input logic tk, input logic [31:0] tg);
    res_valid  = 1;
    res_taken  = tk;
    res_target = tg;
  endtask

  task automatic idle();
    pred_valid = 0;
    res_valid  = 0;
    ext_flush  = 0;
  endtask

  task automatic push(input logic [31:0] pc, input logic tk,
                      input logic [31:0] tg);
    set_push(pc, tk, tg);
    tick();
    idle();
  endtask

  task automatic resolve(input logic tk, input logic [31:0] tg);
    set_res(tk, tg);
    tick();
    idle();
  endtask

  initial begin
    rst_n = 0; rdy = 1;
    pred_pc = 0; pred_taken = 0; pred_target = 0;
    res_taken = 0; res_target = 0;
    idle();
    #12 rst_n = 1;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(pred_ready), 1);
    chk("rst_upd_en", 32'(upd_en), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_upd_addr", upd_addr, 0);
    chk("rst_redirect", redirect_pc, 0);

    // correct predictions
    push(32'h100, 1, 32'h200);
    push(32'h104, 0, 32'h0);
    chk("ok_count2", 32'(count), 2);
    resolve(1, 32'h200);
    chk("ok1_upd_en", 32'(upd_en), 1);
    chk("ok1_addr", upd_addr, 32'h100);
    chk("ok1_res", 32'(upd_res), 1);
    chk("ok1_flush", 32'(flush), 0);
    chk("ok1_count", 32'(count), 1);
    resolve(0, 32'h0);
    chk("ok2_upd_en", 32'(upd_en), 1);
    chk("ok2_addr", upd_addr, 32'h104);
    chk("ok2_res", 32'(upd_res), 0);
    chk("ok2_flush", 32'(flush), 0);
    chk("ok2_count", 32'(count), 0);
    tick();
    chk("ok_upd_clr", 32'(upd_en), 0);

    // direction mispredict with same-cycle push
    push(32'h300, 0, 32'h0);
    push(32'h308, 1, 32'h400);
    push(32'h30c, 0, 32'h0);
    chk("dir_count3", 32'(count), 3);
    set_res(1, 32'h380);
    set_push(32'h500, 0, 32'h0);
    tick();
    idle();
    chk("dir_flush", 32'(flush), 1);
    chk("dir_redirect", redirect_pc, 32'h380);
    chk("dir_upd_res", 32'(upd_res), 1);
    chk("dir_upd_addr", upd_addr, 32'h300);
    chk("dir_count", 32'(count), 0);
    chk("dir_ready", 32'(pred_ready), 0);
    set_push(32'h600, 0, 32'h0);
    tick();
    idle();
    chk("dir_flush_clr", 32'(flush), 0);
    chk("dir_wrongpath", 32'(count), 0);

    // target mispredict and pc+4 wrap
    push(32'h40, 1, 32'h80);
    resolve(1, 32'h90);
    chk("tgt_flush", 32'(flush), 1);
    chk("tgt_redirect", redirect_pc, 32'h90);
    tick();
    push(32'hFFFF_FFFC, 1, 32'h10);
    resolve(0, 32'h0);
    chk("wrap_flush", 32'(flush), 1);
    chk("wrap_redirect", redirect_pc, 32'h0);
    chk("wrap_addr", upd_addr, 32'hFFFF_FFFC);
    tick();

    // full queue, push+pop rejected push
    for (int i = 0; i < 4; i++) push(32'h1000 + 32'(4 * i), 0, 32'h0);
    chk("full_count", 32'(count), 4);
    chk("full_ready", 32'(pred_ready), 0);
    set_push(32'h1010, 0, 32'h0);
    set_res(0, 32'h0);
    tick();
    idle();
    chk("full_pp_count", 32'(count), 3);
    chk("full_pp_addr", upd_addr, 32'h1000);
    for (int i = 1; i < 4; i++) begin
      resolve(0, 32'h0);
      chk("full_drain_addr", upd_addr, 32'h1000 + 32'(4 * i));
    end
    chk("full_empty", 32'(count), 0);

    // wrap-around streaming past 2*DEPTH entries
    push(32'h2000, 0, 32'h0);
    for (int i = 1; i < 10; i++) begin
      set_push(32'h2000 + 32'(4 * i), 0, 32'h0);
      set_res(0, 32'h0);
      tick();
      idle();
      chk("stream_addr", upd_addr, 32'h2000 + 32'(4 * (i - 1)));
      chk("stream_count", 32'(count), 1);
    end
    resolve(0, 32'h0);
    chk("stream_last", upd_addr, 32'h2024);
    chk("stream_flush", 32'(flush), 0);

    // ext_flush beats resolve and push
    push(32'h2100, 0, 32'h0);
    push(32'h2104, 0, 32'h0);
    resolve(0, 32'h0);
    chk("xf_pre_upd", 32'(upd_en), 1);
    ext_flush = 1;
    set_res(1, 32'h999);
    set_push(32'h2200, 0, 32'h0);
    tick();
    idle();
    chk("xf_count", 32'(count), 0);
    chk("xf_upd_en", 32'(upd_en), 0);
    chk("xf_flush", 32'(flush), 0);

    // resolve with empty queue
    resolve(1, 32'h123);
    chk("empty_upd_en", 32'(upd_en), 0);
    chk("empty_flush", 32'(flush), 0);
    chk("empty_count", 32'(count), 0);

    // rdy low holds everything
    push(32'h3000, 0, 32'h0);
    push(32'h3004, 0, 32'h0);
    resolve(0, 32'h0);
    chk("rdy_pre_upd", 32'(upd_en), 1);
    rdy = 0;
    set_res(1, 32'h777);
    set_push(32'h3100, 0, 32'h0);
    tick();
    idle();
    rdy = 1;
    chk("rdy_upd_hold", 32'(upd_en), 1);
    chk("rdy_addr_hold", upd_addr, 32'h3000);
    chk("rdy_count_hold", 32'(count), 1);
    chk("rdy_flush_hold", 32'(flush), 0);
    tick();
    chk("rdy_upd_clr", 32'(upd_en), 0);
    chk("rdy_count", 32'(count), 1);

    // async reset mid-stream
    push(32'h3008, 0, 32'h0);
    push(32'h300c, 0, 32'h0);
    chk("mrst_pre", 32'(count), 3);
    #2 rst_n = 0;
    #1;
    chk("mrst_count", 32'(count), 0);
    chk("mrst_flush", 32'(flush), 0);
    chk("mrst_upd_en", 32'(upd_en), 0);
    chk("mrst_ready", 32'(pred_ready), 1);
    #2 rst_n = 1;
    resolve(0, 32'h0);
    chk("mrst_after_upd", 32'(upd_en), 0);
    chk("mrst_after_cnt", 32'(count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
